// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: Y86-64 SEQ sequencer, one-hot stage enables, dmem handshake.
// Define SEQ_INSTR_CNT_EN to add the o_instr_count retired-instruction counter.
module seq_stage_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_icode,
  input  logic             i_instr_valid,
  input  logic             i_imem_error,
  input  logic             i_dmem_ack,
  input  logic             i_dmem_error,
  output logic             o_fetch_en,
  output logic             o_decode_en,
  output logic             o_execute_en,
  output logic             o_memory_en,
  output logic             o_writeback_en,
  output logic             o_pc_en,
  output logic             o_dmem_req,
  output logic             o_busy,
  output logic [2:0]       o_stat,
  output logic [CNT_W-1:0] o_cycle_count
`ifdef SEQ_INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0] o_instr_count
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
    S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_icode;
  logic [2:0]       r_stat, w_stat;
  logic [TW-1:0]    r_tmo;
  logic [CNT_W-1:0] r_cyc;
  logic             w_mem_op, w_wb_op, w_tmo_hit;

  always_comb begin
    w_mem_op = 1'b0;
    w_wb_op  = 1'b0;
    case (r_icode)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_mem_op = 1'b1;
      4'h2, 4'h3, 4'h6:                   w_wb_op  = 1'b1;
      default: ;
    endcase
  end

  // The cycle that brings the wait count to MEM_TIMEOUT is the last allowed
  assign w_tmo_hit = (r_tmo == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    w_stat = r_stat;
    unique case (r_state)
      S_IDLE:
        if (i_start) w_next = S_FETCH;
      S_FETCH:
        if (i_imem_error) begin
          w_next = S_HALT;
          w_stat = ST_ADR;
        end else if (!i_instr_valid) begin
          w_next = S_HALT;
          w_stat = ST_INS;
        end else if (i_icode == 4'h0) begin
          w_next = S_HALT;
          w_stat = ST_HLT;
        end else begin
          w_next = S_DECODE;
        end
      S_DECODE:
        w_next = S_EXECUTE;
      S_EXECUTE:
        if (w_mem_op)     w_next = S_MEMORY;
        else if (w_wb_op) w_next = S_WRITEBACK;
        else              w_next = S_PCUPD;
      S_MEMORY:
        if (i_dmem_error || (!i_dmem_ack && w_tmo_hit)) begin
          w_next = S_HALT;
          w_stat = ST_ADR;
        end else if (i_dmem_ack) begin
          w_next = (r_icode == 4'h4) ? S_PCUPD : S_WRITEBACK;
        end
      S_WRITEBACK:
        w_next = S_PCUPD;
      S_PCUPD:
        w_next = S_FETCH;
      S_HALT:
        w_next = S_HALT;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_stat  <= ST_AOK;
      r_icode <= 4'h0;
      r_tmo   <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_next;
      r_stat  <= w_stat;
      if (r_state == S_FETCH) r_icode <= i_icode;
      r_tmo <= (r_state == S_MEMORY) ? r_tmo + TW'(1) : '0;
      if (o_busy && r_cyc != '1) r_cyc <= r_cyc + CNT_W'(1);
    end
  end

`ifdef SEQ_INSTR_CNT_EN
  logic [CNT_W-1:0] r_icnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_icnt <= '0;
    else if (r_state == S_PCUPD && r_icnt != '1)
      r_icnt <= r_icnt + CNT_W'(1);
  end

  assign o_instr_count = r_icnt;
`endif

  assign o_fetch_en     = (r_state == S_FETCH);
  assign o_decode_en    = (r_state == S_DECODE);
  assign o_execute_en   = (r_state == S_EXECUTE);
  assign o_memory_en    = (r_state == S_MEMORY);
  assign o_writeback_en = (r_state == S_WRITEBACK);
  assign o_pc_en        = (r_state == S_PCUPD);
  assign o_dmem_req     = (r_state == S_MEMORY);
  assign o_busy         = (r_state != S_IDLE) && (r_state != S_HALT);
  assign o_stat         = r_stat;
  assign o_cycle_count  = r_cyc;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb_seq_stage_ctrl: table vectors, corner sequences and random instructions
// checked against a stage-trace model of the SEQ sequencer.
module tb_seq_stage_ctrl;

  localparam int CW     = 8;
  localparam int CMAX   = 255;
  localparam int MEM_TO = 16;

  logic          clk = 0, rst = 0, start = 0;
  logic [3:0]    icode = 0;
  logic          valid = 1, imerr = 0, ack = 0, derr = 0;
  logic          fetch_en, decode_en, execute_en, memory_en;
  logic          writeback_en, pc_en, dmem_req, busy;
  logic [2:0]    stat;
  logic [CW-1:0] cycle_count;
`ifdef SEQ_INSTR_CNT_EN
  logic [CW-1:0] instr_count;
`endif
  logic [5:0]    en_vec;

  seq_stage_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(MEM_TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_icode(icode),
    .i_instr_valid(valid), .i_imem_error(imerr),
    .i_dmem_ack(ack), .i_dmem_error(derr),
    .o_fetch_en(fetch_en), .o_decode_en(decode_en),
    .o_execute_en(execute_en), .o_memory_en(memory_en),
    .o_writeback_en(writeback_en), .o_pc_en(pc_en),
    .o_dmem_req(dmem_req), .o_busy(busy), .o_stat(stat),
    .o_cycle_count(cycle_count)
`ifdef SEQ_INSTR_CNT_EN
    , .o_instr_count(instr_count)
`endif
  );

  assign en_vec = {fetch_en, decode_en, execute_en,
                   memory_en, writeback_en, pc_en};

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ic;
    bit         v;
    bit         ie;
    int         w;
    bit         de;
    string      tr;
    logic [2:0] st;
  } vec_t;

  vec_t  tab [19];
  int    n_cmp = 0, n_bad = 0;
  int    exp_cyc = 0, exp_ic = 0;
  string m8 = "MMMMMMMM";

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] en_of(input byte c);
    case (c)
      "F":     return 6'b100000;
      "D":     return 6'b010000;
      "E":     return 6'b001000;
      "M":     return 6'b000100;
      "W":     return 6'b000010;
      "P":     return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // Expected stage trace and final stat, straight from the instruction rules
  function automatic void model(input logic [3:0] ic, input bit v,
                                input bit ie, input int w, input bit de,
                                output string tr, output logic [2:0] st);
    int mc;
    st = 3'd1;
    if (ie) begin
      tr = "F"; st = 3'd3;
    end else if (!v) begin
      tr = "F"; st = 3'd4;
    end else if (ic == 4'h0) begin
      tr = "F"; st = 3'd2;
    end else begin
      tr = "FDE";
      if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
        mc = (w >= MEM_TO) ? MEM_TO : w + 1;
        for (int k = 0; k < mc; k++) tr = {tr, "M"};
        if (w >= MEM_TO || de) st = 3'd3;
        else if (ic == 4'h4)   tr = {tr, "P"};
        else                   tr = {tr, "WP"};
      end else if (ic inside {4'h2, 4'h3, 4'h6}) begin
        tr = {tr, "WP"};
      end else begin
        tr = {tr, "P"};
      end
    end
  endfunction

  task automatic do_reset;
    rst = 1; start = 0; ack = 0; derr = 0; valid = 1; imerr = 0;
    #2;
    chk("rst_en", en_vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stat", stat, 1);
    chk("rst_cyc", cycle_count, 0);
    tick;
    rst = 0;
    exp_cyc = 0;
    exp_ic = 0;
`ifdef SEQ_INSTR_CNT_EN
    chk("rst_icnt", instr_count, 0);
`endif
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("idle_en", en_vec, 0);
      chk("idle_busy", busy, 0);
      chk("idle_stat", stat, 1);
      chk("idle_cyc", cycle_count, 0);
    end
    start = 1;
    tick;
    start = 0;
  endtask

  // Expects the DUT in FETCH; steps the trace, then checks the outcome
  task automatic run_instr(input vec_t v);
    int  m;
    byte c;
    m = 0;
    for (int p = 0; p < v.tr.len(); p++) begin
      c = v.tr[p];
      chk("stage_en", en_vec, en_of(c));
      chk("busy", busy, 1);
      chk("dmem_req", dmem_req, (c == "M") ? 1 : 0);
      start = 1'($urandom_range(0, 1));
      ack = 0;
      derr = 0;
      if (c == "F") begin
        icode = v.ic; valid = v.v; imerr = v.ie;
      end else begin
        icode = 4'($urandom); valid = 1; imerr = 0;
      end
      if (c == "M") begin
        if (m == v.w) begin
          ack = 1; derr = v.de;
        end
        m++;
      end else begin
        ack = 1'($urandom_range(0, 1));
      end
      exp_cyc = sat(exp_cyc + 1);
      tick;
    end
    start = 0; ack = 0; derr = 0;
    chk("cycle_count", cycle_count, exp_cyc);
    chk("stat", stat, v.st);
    if (v.st == 3'd1) begin
      exp_ic = sat(exp_ic + 1);
`ifdef SEQ_INSTR_CNT_EN
      chk("instr_count", instr_count, exp_ic);
`endif
      chk("refetch", fetch_en, 1);
    end else begin
      chk("halt_en", en_vec, 0);
      chk("halt_busy", busy, 0);
`ifdef SEQ_INSTR_CNT_EN
      chk("halt_icnt", instr_count, exp_ic);
`endif
      start = 1;
      tick;
      tick;
      start = 0;
      chk("halt_hold_en", en_vec, 0);
      chk("halt_hold_stat", stat, v.st);
      chk("halt_hold_cyc", cycle_count, exp_cyc);
      do_reset;
    end
  endtask

  initial begin
    vec_t r;
    tab[0]  = '{4'h1, 1, 0, 0,  0, "FDEP",     3'd1};
    tab[1]  = '{4'h5, 1, 0, 2,  0, "FDEMMMWP", 3'd1};
    tab[2]  = '{4'h4, 1, 0, 0,  0, "FDEMP",    3'd1};
    tab[3]  = '{4'h2, 1, 0, 0,  0, "FDEWP",    3'd1};
    tab[4]  = '{4'h7, 1, 0, 0,  0, "FDEP",     3'd1};
    tab[5]  = '{4'h3, 1, 0, 0,  0, "FDEWP",    3'd1};
    tab[6]  = '{4'h6, 1, 0, 0,  0, "FDEWP",    3'd1};
    tab[7]  = '{4'h8, 1, 0, 0,  0, "FDEMWP",   3'd1};
    tab[8]  = '{4'h9, 1, 0, 1,  0, "FDEMMWP",  3'd1};
    tab[9]  = '{4'hB, 1, 0, 0,  0, "FDEMWP",   3'd1};
    tab[10] = '{4'h9, 1, 0, 15, 0, {"FDE", m8, m8, "WP"}, 3'd1};
    tab[11] = '{4'h4, 1, 0, 3,  0, "FDEMMMMP", 3'd1};
    tab[12] = '{4'h0, 1, 0, 0,  0, "F",        3'd2};
    tab[13] = '{4'h5, 1, 1, 0,  0, "F",        3'd3};
    tab[14] = '{4'h5, 0, 0, 0,  0, "F",        3'd4};
    tab[15] = '{4'h3, 0, 1, 0,  0, "F",        3'd3};
    tab[16] = '{4'h8, 1, 0, 0,  1, "FDEM",     3'd3};
    tab[17] = '{4'hA, 1, 0, 99, 0, {"FDE", m8, m8}, 3'd3};
    tab[18] = '{4'hB, 1, 0, 2,  1, "FDEMMM",   3'd3};

    #1;
    do_reset;
    foreach (tab[i]) run_instr(tab[i]);

    // reset in the middle of a memory wait
    icode = 4'h5; valid = 1; imerr = 0; ack = 0;
    tick; tick; tick;
    chk("mr_req_on", dmem_req, 1);
    tick;
    #2 rst = 1;
    #1;
    chk("mr_req_off", dmem_req, 0);
    chk("mr_mem_en", memory_en, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cyc", cycle_count, 0);
    chk("mr_stat", stat, 1);
    do_reset;

    // cycle_count saturation over a long nop run
    for (int i = 0; i < 70; i++) run_instr(tab[0]);
    chk("cyc_sat", cycle_count, CMAX);

    for (int i = 0; i < 300; i++) begin
      int sel;
      sel  = $urandom_range(0, 99);
      r.ic = (sel < 3) ? 4'h0 :
             (sel < 6) ? 4'($urandom_range(12, 15)) :
                         4'($urandom_range(1, 11));
      r.v  = ($urandom_range(0, 29) != 0);
      r.ie = ($urandom_range(0, 39) == 0);
      r.w  = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 18)
                                          : $urandom_range(0, 3);
      r.de = ($urandom_range(0, 19) == 0);
      model(r.ic, r.v, r.ie, r.w, r.de, r.tr, r.st);
      run_instr(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
